e_mdu_iter: RTL and testbench
=============================

# e_mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers for the execute stage of the pipelined core. It replaces the fixed-width, fixed-latency HI/LO unit: operand width, multiply latency and an optional multiply-accumulate group are configurable. Division is a real bit-serial restoring divider rather than a single-cycle operator. The unit also gains a cancel input for pipeline flushes, a completion pulse, and defined results for divide-by-zero and signed overflow.

## Interface
- WIDTH, 32: operand and HI/LO register width, ≥ 8.
- MUL_LAT, 5: busy cycles for a multiply-class operation, ≥ 1.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a  in  WIDTH  rs operand / dividend / mthi/mtlo data.
- b  in  WIDTH  rt operand / divisor.
- md_type  in  4  op: 0000 none, 0001 div, 0010 divu, 0011 mult, 0100 multu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo, 1001 msub, 1010 madd, 1011 maddu, 1100 msubu.
- cancel  in  1  flush; aborts the in-flight op and blocks acceptance this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- start  out  1  combinational: idle && md_type is a compute op && !cancel.
- busy  out  1  registered; high while an op is in flight.
- done  out  1  registered one-cycle pulse; HI/LO were updated at the preceding edge.

## Operation
- States: IDLE, MUL, DIV. Down-counter of width $clog2(max(MUL_LAT, WIDTH+1)+1).
- IDLE with start high: latch a, b and op. Go to MUL with count=MUL_LAT, or to DIV with count=WIDTH+1.
- IDLE with mthi/mtlo and !cancel: write a into HI/LO at the edge. mfhi/mflo need no action; hi/lo are always visible.
- Any md_type while busy is ignored. The hazard unit stalls the issuing instruction on start || busy.
- MUL: product is the full 2·WIDTH-bit product, signed for mult/madd/msub and unsigned for multu/maddu/msubu. Written at the final edge.
  - mult/multu: {HI,LO} = product.
  - madd/maddu: {HI,LO} += product.
  - msub/msubu: {HI,LO} −= product.
  - Accumulation is modulo 2^(2·WIDTH) and uses HI/LO as held at the final edge.
- DIV: restoring divider on magnitudes (signed ops take the absolute value of operands).
  - WIDTH shift/subtract cycles, then one sign-fix cycle.
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divisor zero: LO = all ones, HI = a. No exception.
- Signed overflow (a = MIN, b = −1): LO = MIN, HI = 0.
- cancel while busy: return to IDLE at the next edge. HI/LO are unchanged and done stays low.

## Timing
- Reset (async assert, sync release): state IDLE, count 0, hi=0, lo=0, busy=0, done=0, latched operands 0.
- Accept at edge k. busy is high in cycles k+1 … k+N, where N = MUL_LAT (multiply class) or WIDTH+1 (divide).
- HI/LO are written at edge k+N. In cycle k+N+1: busy=0, done=1, hi/lo hold the new values.
- Back-to-back: a new op may be accepted in the done cycle, so throughput is one op per N+1 cycles.
- mthi/mtlo take effect at the accepting edge; latency is 1 with no busy and no done.
- cancel and start in the same IDLE cycle: start=0, nothing is accepted.
- cancel in the final busy cycle: abort wins and HI/LO are not written.
- reset_n low mid-operation: immediate return to reset values, and the partial result is discarded.

## Configuration
- MDU_MACC_EN defined: madd, maddu, msub and msubu (1001–1100) execute as described.
- MDU_MACC_EN undefined: those codes decode as none. start stays 0 and HI/LO are untouched. The accumulate adder is not synthesised.

## Test plan
- WIDTH=32, mult a=0xFFFFFFFD (−3), b=7 -> busy for 5 cycles, then done. HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- divu a=100, b=7 -> busy for 33 cycles, then LO=14, HI=2. div a=−7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div a=5, b=0 -> LO=0xFFFFFFFF, HI=5. div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0, mtlo 10, then msub a=2, b=3 (MDU_MACC_EN on) -> HI=0, LO=4. The same sequence with the macro off -> start stays 0, HI=0, LO=10.
- divu starts, cancel asserted in busy cycle 10 -> busy falls at the next edge, done stays 0, HI/LO keep their prior values. mtlo issued during busy -> LO unchanged.
- reset_n pulsed low mid-mult -> hi=lo=0 and busy=0 immediately. The next mult after release completes normally after MUL_LAT cycles.

Source files
------------

// File: rtl/e_mdu_iter.sv
// -----------------------------------------------------------------------------
// e_mdu_iter -- iterative multiply/divide unit with HI/LO result registers for
// the execute stage.
//
// A multiply-class op keeps the unit busy for MUL_LAT cycles. The full
// 2*WIDTH-bit product is written to {HI,LO} at the final edge. A divide keeps
// it busy for WIDTH+1 cycles: WIDTH restoring shift/subtract steps on operand
// magnitudes, followed by one sign-fix cycle that writes LO=quotient and
// HI=remainder. mthi/mtlo write HI/LO directly while idle.
//
// Optional feature macro: MDU_MACC_EN
//   defined   -> madd/maddu/msub/msubu accumulate into {HI,LO}
//   undefined -> those codes decode as "none" and no accumulate adder exists
//
// Parameters: WIDTH   operand and HI/LO width (>= 8)
//             MUL_LAT busy cycles for a multiply-class op (>= 1)
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   a        in   rs operand / dividend / mthi-mtlo data
//   b        in   rt operand / divisor
//   md_type  in   operation code
//   cancel   in   flush: aborts the in-flight op, blocks acceptance this cycle
//   hi, lo   out  HI/LO registers
//   start    out  idle && compute op && !cancel (combinational)
//   busy     out  an op is in flight (from registered state)
//   done     out  one-cycle pulse after HI/LO were written by a compute op
// -----------------------------------------------------------------------------
module e_mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       md_type,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             start,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MACC_EN
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MADD  = 4'd10;
  localparam logic [3:0] OP_MADDU = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam int            MAX_N = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
  localparam int            CW    = $clog2(MAX_N + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_N = CW'(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0] r_rem, r_quo;   // partial remainder / dividend-out quotient-in
  logic [3:0]       r_op;
  logic             r_done;

  logic             w_is_mul, w_is_div, w_idle;
  logic             w_a_neg_in, w_a_neg, w_b_neg, w_mul_signed;
  logic [WIDTH-1:0] w_a_mag_in, w_b_mag, w_q_fix, w_r_fix, w_div_hi, w_div_lo;
  logic [WIDTH:0]   w_sh, w_diff;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_mul_res;

  // ---------------- decode ----------------
  always_comb begin
    w_is_mul = (md_type == OP_MULT) || (md_type == OP_MULTU);
`ifdef MDU_MACC_EN
    w_is_mul = w_is_mul || (md_type == OP_MSUB) || (md_type == OP_MADD) ||
               (md_type == OP_MADDU) || (md_type == OP_MSUBU);
`endif
    w_is_div = (md_type == OP_DIV) || (md_type == OP_DIVU);
  end

  assign w_idle = (r_state == S_IDLE);
  assign start  = w_idle && (w_is_mul || w_is_div) && !cancel;
  assign busy   = !w_idle;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;

  // ---------------- multiply ----------------
  always_comb begin
    w_mul_signed = (r_op == OP_MULT);
`ifdef MDU_MACC_EN
    w_mul_signed = w_mul_signed || (r_op == OP_MADD) || (r_op == OP_MSUB);
`endif
  end

  // Extending to 2*WIDTH and multiplying modulo 2^(2*WIDTH) gives the exact
  // signed or unsigned product.
  assign w_ext_a = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_mul_res = w_prod;
`ifdef MDU_MACC_EN
    if ((r_op == OP_MADD) || (r_op == OP_MADDU))
      w_mul_res = {r_hi, r_lo} + w_prod;
    else if ((r_op == OP_MSUB) || (r_op == OP_MSUBU))
      w_mul_res = {r_hi, r_lo} - w_prod;
`endif
  end

  // ---------------- divide ----------------
  assign w_a_neg_in = (md_type == OP_DIV) && a[WIDTH-1];
  assign w_a_mag_in = w_a_neg_in ? -a : a;
  assign w_a_neg    = (r_op == OP_DIV) && r_a[WIDTH-1];
  assign w_b_neg    = (r_op == OP_DIV) && r_b[WIDTH-1];
  assign w_b_mag    = w_b_neg ? -r_b : r_b;

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not go negative.
  assign w_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, w_b_mag};

  // MIN / -1 needs no special case: |MIN| / 1 = 2^(WIDTH-1), whose negation
  // wraps back to MIN with a zero remainder.
  assign w_q_fix  = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
  assign w_r_fix  = w_a_neg ? -r_rem : r_rem;
  assign w_div_lo = (r_b == '0) ? '1  : w_q_fix;
  assign w_div_hi = (r_b == '0) ? r_a : w_r_fix;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_is_mul ? S_MUL : S_DIV;
      default: if (cancel || (r_cnt == LAST)) w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_idle) begin
        if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_op  <= md_type;
          r_cnt <= w_is_mul ? MUL_N : DIV_N;
          r_rem <= '0;
          r_quo <= w_a_mag_in;
        end else if (!cancel && (md_type == OP_MTHI)) begin
          r_hi <= a;
        end else if (!cancel && (md_type == OP_MTLO)) begin
          r_lo <= a;
        end
      end else if (cancel) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == LAST) begin
          r_done <= 1'b1;
          if (r_state == S_MUL) begin
            {r_hi, r_lo} <= w_mul_res;
          end else begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
        end else if (r_state == S_DIV) begin
          r_rem <= w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        end
      end
    end
  end

endmodule

// File: tb/tb_e_mdu_iter.sv
module tb_e_mdu_iter;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DN = W + 1;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  a, b, hi, lo;
  logic [3:0]    md_type;
  logic          cancel, start, busy, done;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   sb_q[$];
  logic [63:0]   m_hilo;

  e_mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .md_type (md_type),
    .cancel  (cancel),
    .hi      (hi),
    .lo      (lo),
    .start   (start),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results computed with native 64-bit / 32-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              qi, ri;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (op)
      4'd3:  return 64'(sx * sy);
      4'd4:  return 64'(ux * uy);
      4'd9:  return acc - 64'(sx * sy);
      4'd10: return acc + 64'(sx * sy);
      4'd11: return acc + 64'(ux * uy);
      4'd12: return acc - 64'(ux * uy);
      4'd1: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
      end
      4'd2: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return acc;
    endcase
  endfunction

  // Drive a compute op in the current cycle and step past the accepting edge.
  task automatic issue_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit push);
    if (push) sb_q.push_back(model(op, x, y, m_hilo));
    md_type = op; a = x; b = y;
    #1;
    chk({tag, ".start"}, 64'(start), 64'(1));
    @(posedge clk); #1;
    md_type = 4'd0;
  endtask

  // Wait for the end of busy, then check latency, done and the scoreboard.
  task automatic finish_op(input string tag, input int n, input int cyc0);
    int          cyc;
    logic [63:0] e;
    cyc = cyc0;
    while (busy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(n));
    chk({tag, ".done"}, 64'(done), 64'(1));
    e = sb_q.pop_front();
    chk({tag, ".hilo"}, {hi, lo}, e);
    m_hilo = e;
    $display("op %s: busy=%0d hi=%h lo=%h", tag, cyc, hi, lo);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int n);
    issue_op(tag, op, x, y, 1'b1);
    finish_op(tag, n, 0);
  endtask

  task automatic mt(input string tag, input logic [3:0] op, input logic [31:0] x);
    md_type = op; a = x;
    #1;
    chk({tag, ".start"}, 64'(start), 64'(0));
    @(posedge clk); #1;
    md_type = 4'd0;
    if (op == 4'd7) m_hilo[63:32] = x;
    else            m_hilo[31:0]  = x;
    chk({tag, ".hilo"}, {hi, lo}, m_hilo);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    $display("op %s: a=%h hi=%h lo=%h", tag, x, hi, lo);
  endtask

  // Abort after 'k' busy cycles (cancel raised in busy cycle k).
  task automatic cancel_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input int k);
    issue_op(tag, op, x, y, 1'b0);
    repeat (k - 1) @(posedge clk);
    #1;
    chk({tag, ".busy_pre"}, 64'(busy), 64'(1));
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".hilo"}, {hi, lo}, m_hilo);
    @(posedge clk); #1;
    chk({tag, ".done_after"}, 64'(done), 64'(0));
    $display("op %s: cancelled in busy cycle %0d hi=%h lo=%h", tag, k, hi, lo);
  endtask

  initial begin
    reset_n = 1'b0; cancel = 1'b0; md_type = 4'd0; a = '0; b = '0; m_hilo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hilo", {hi, lo}, 64'h0);
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.start", 64'(start), 64'(0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed multiply / divide cases, issued back-to-back in done cycles.
    do_op("mult",      4'd3, 32'hFFFF_FFFD, 32'd7, ML);
    chk("mult.exp",  {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("multu",     4'd4, 32'hFFFF_FFFD, 32'd7, ML);
    chk("multu.exp", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
    do_op("divu",      4'd2, 32'd100, 32'd7, DN);
    chk("divu.exp",  {hi, lo}, {32'd2, 32'd14});
    do_op("div_neg",   4'd1, 32'hFFFF_FFF9, 32'd2, DN);
    chk("div_neg.exp", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("div_zero",  4'd1, 32'd5, 32'd0, DN);
    chk("div_zero.exp", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op("div_ovf",   4'd1, 32'h8000_0000, 32'hFFFF_FFFF, DN);
    chk("div_ovf.exp", {hi, lo}, {32'h0, 32'h8000_0000});
    do_op("divu_zero", 4'd2, 32'hDEAD_BEEF, 32'd0, DN);

    for (int i = 0; i < 4; i++) begin
      do_op("rnd_mult",  4'd3, $urandom, $urandom, ML);
      do_op("rnd_multu", 4'd4, $urandom, $urandom, ML);
      do_op("rnd_div",   4'd1, $urandom, $urandom >> $urandom_range(0, 31), DN);
      do_op("rnd_divu",  4'd2, $urandom, $urandom >> $urandom_range(0, 31), DN);
    end

    // Move-to and the optional accumulate group.
    mt("mthi", 4'd7, 32'd0);
    mt("mtlo", 4'd8, 32'd10);
`ifdef MDU_MACC_EN
    do_op("msub",  4'd9,  32'd2, 32'd3, ML);
    chk("msub.exp", {hi, lo}, {32'd0, 32'd4});
    do_op("madd",  4'd10, 32'hFFFF_FFFF, 32'd2, ML);
    do_op("maddu", 4'd11, 32'hFFFF_FFFF, 32'd2, ML);
    do_op("msubu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML);
`else
    md_type = 4'd9; a = 32'd2; b = 32'd3;
    #1;
    chk("msub_off.start", 64'(start), 64'(0));
    repeat (ML + 2) @(posedge clk);
    #1;
    md_type = 4'd0;
    chk("msub_off.busy", 64'(busy), 64'(0));
    chk("msub_off.done", 64'(done), 64'(0));
    chk("msub_off.hilo", {hi, lo}, {32'd0, 32'd10});
    $display("op msub (disabled): hi=%h lo=%h", hi, lo);
`endif

    // Flushes.
    cancel_op("divu_cancel",      4'd2, 32'd1000, 32'd3, 10);
    cancel_op("mult_cancel_last", 4'd3, 32'd9,    32'd9, ML);

    md_type = 4'd3; a = 32'd4; b = 32'd4; cancel = 1'b1;
    #1;
    chk("cancel_start.start", 64'(start), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b0; md_type = 4'd0;
    chk("cancel_start.busy", 64'(busy), 64'(0));
    chk("cancel_start.hilo", {hi, lo}, m_hilo);
    $display("op mult+cancel same cycle: busy=%0d", busy);

    md_type = 4'd8; a = 32'h1234; cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; md_type = 4'd0;
    chk("mtlo_cancel.hilo", {hi, lo}, m_hilo);
    $display("op mtlo+cancel: lo=%h", lo);

    // mtlo during busy is ignored.
    issue_op("divu_mtlo", 4'd2, 32'd53, 32'd5, 1'b1);
    md_type = 4'd8; a = 32'h1234;
    @(posedge clk); #1;
    md_type = 4'd0;
    chk("mtlo_busy.lo", {32'h0, lo}, {32'h0, m_hilo[31:0]});
    finish_op("divu_mtlo", DN, 1);

    // Reset mid-multiply.
    mt("mthi2", 4'd7, 32'hABCD_0123);
    issue_op("mult_rst", 4'd3, 32'd5, 32'd6, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    m_hilo = '0;
    chk("rst_mid.hilo", {hi, lo}, 64'h0);
    chk("rst_mid.busy", 64'(busy), 64'(0));
    chk("rst_mid.done", 64'(done), 64'(0));
    $display("op reset mid-mult: hi=%h lo=%h busy=%0d", hi, lo, busy);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    do_op("mult_after_rst", 4'd3, 32'd5, 32'd6, ML);
    chk("mult_after_rst.exp", {hi, lo}, 64'd30);
    @(posedge clk); #1;
    chk("done_pulse_end", 64'(done), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
